// File: rtl/pc_fetch_controller_pkg.sv
// Shared definitions for the fetch controller: state encoding, default
// reset/step values and the instruction-alignment width.
package pc_fetch_controller_pkg;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_HALTED = 2'd3
    } fetch_state_e;

    localparam int unsigned DEFAULT_PC_STEP      = 4;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

    // Number of low address bits forced to zero on every redirect target.
    localparam int unsigned ALIGN_BITS = 2;

endpackage

// File: rtl/pc_fetch_controller_adder.sv
// Sequential PC adder: pc_new_o = pc_old_i + STEP, modulo 2^ADDR_WIDTH.
module pc_fetch_controller_adder #(
    parameter int          ADDR_WIDTH = 32,
    parameter int unsigned STEP       = 4
) (
    input  logic [ADDR_WIDTH-1:0] pc_old_i,
    output logic [ADDR_WIDTH-1:0] pc_new_o
);

    assign pc_new_o = pc_old_i + ADDR_WIDTH'(STEP);

endmodule

// File: rtl/pc_fetch_controller.sv
// Program-counter sequencer with a single-outstanding instruction fetch
// handshake, next-PC selection and redirect/halt handling.
module pc_fetch_controller
    import pc_fetch_controller_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(DEFAULT_RESET_VECTOR),
    parameter int unsigned           PC_STEP      = DEFAULT_PC_STEP
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    input  logic                  jump,
    input  logic [ADDR_WIDTH-1:0] jump_target,
    input  logic                  halt,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    output logic                  fetch_valid,
    output logic [ADDR_WIDTH-1:0] fetch_pc,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [ADDR_WIDTH-1:0] pc_plus4,
    output logic                  halted,
    output logic [1:0]            dbg_state
);

    // Handshake: imem_req rises in the cycle after FETCH issues and stays high
    // with imem_addr frozen until the cycle in which imem_ack is sampled high;
    // an ack seen while imem_req is low (BOOT/FETCH/HALTED) has no effect.

    localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'((1 << ALIGN_BITS) - 1);

    function automatic logic [ADDR_WIDTH-1:0] align_addr(input logic [ADDR_WIDTH-1:0] a);
        return a & ~LOW_MASK;
    endfunction

    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  req_q, req_d;
    logic                  fv_q, fv_d;
    logic [ADDR_WIDTH-1:0] fpc_q, fpc_d;
    logic                  pend_vld_q, pend_vld_d;
    logic                  pend_jmp_q, pend_jmp_d;
    logic [ADDR_WIDTH-1:0] pend_tgt_q, pend_tgt_d;
    logic [ADDR_WIDTH-1:0] pc_seq_w;
    logic                  redirect_now;
    logic [ADDR_WIDTH-1:0] redirect_tgt;

    pc_fetch_controller_adder #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .STEP      (PC_STEP)
    ) u_adder (
        .pc_old_i(pc_q),
        .pc_new_o(pc_seq_w)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_d        = 1'b0;
        fv_d         = 1'b0;
        fpc_d        = fpc_q;
        pend_vld_d   = pend_vld_q;
        pend_jmp_d   = pend_jmp_q;
        pend_tgt_d   = pend_tgt_q;
        redirect_now = jump | branch_taken;
        redirect_tgt = jump ? align_addr(jump_target) : align_addr(branch_target);

        case (state_q)
            ST_BOOT: state_d = ST_FETCH;
            ST_FETCH: begin
                // A redirect here retargets pc without issuing the stale fetch.
                if (halt) begin
                    state_d = ST_HALTED;
                end else if (redirect_now) begin
                    pc_d = redirect_tgt;
                end else if (!stall) begin
                    req_d   = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                req_d = 1'b1;
                if (imem_ack) begin
                    req_d      = 1'b0;
                    pend_vld_d = 1'b0;
                    pend_jmp_d = 1'b0;
                    if (redirect_now) begin
                        pc_d = redirect_tgt;
                    end else if (pend_vld_q) begin
                        pc_d = pend_tgt_q;
                    end else begin
                        pc_d  = pc_seq_w;
                        fv_d  = 1'b1;
                        fpc_d = pc_q;
                    end
                    state_d = halt ? ST_HALTED : ST_FETCH;
                end else if (jump) begin
                    pend_vld_d = 1'b1;
                    pend_jmp_d = 1'b1;
                    pend_tgt_d = align_addr(jump_target);
                end else if (branch_taken && !pend_jmp_q) begin
                    // A latched jump outranks any later branch.
                    pend_vld_d = 1'b1;
                    pend_tgt_d = align_addr(branch_target);
                end
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_VECTOR;
            req_q      <= 1'b0;
            fv_q       <= 1'b0;
            fpc_q      <= RESET_VECTOR;
            pend_vld_q <= 1'b0;
            pend_jmp_q <= 1'b0;
            pend_tgt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_q      <= req_d;
            fv_q       <= fv_d;
            fpc_q      <= fpc_d;
            pend_vld_q <= pend_vld_d;
            pend_jmp_q <= pend_jmp_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign fetch_valid = fv_q;
    assign fetch_pc    = fpc_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_seq_w;
    assign halted      = (state_q == ST_HALTED);
    assign dbg_state   = state_q;

endmodule

// File: doc/pc_fetch_controller.md
Name: pc_fetch_controller

Overview:
- Sequences the program counter and the instruction-memory fetch handshake for the core.
- Owns the PC register and drives the PC+4 adder path.
- Selects the next PC from sequential, branch and jump sources.
- Issues one outstanding fetch at a time and signals the decode stage when the fetched instruction is valid.

Parameters:
- ADDR_WIDTH, 32, width of PC and memory addresses
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
- PC_STEP, 4, sequential increment in bytes

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- stall  in  1  pipeline stall; no new fetch issued while high
- branch_taken  in  1  redirect request, branch source
- branch_target  in  ADDR_WIDTH  branch destination
- jump  in  1  redirect request, jump source; has priority over branch
- jump_target  in  ADDR_WIDTH  jump destination
- halt  in  1  stop fetching after current fetch completes
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  ADDR_WIDTH  fetch address, always equals pc
- imem_ack  in  1  memory has returned data for the current request
- fetch_valid  out  1  one-cycle pulse: instruction for fetch_pc is valid
- fetch_pc  out  ADDR_WIDTH  PC of the instruction marked by fetch_valid
- pc  out  ADDR_WIDTH  current PC register
- pc_plus4  out  ADDR_WIDTH  pc + PC_STEP (combinational)
- halted  out  1  high in HALTED state

Behaviour:
- Reset (asynchronous, any state):
  - pc = RESET_VECTOR; state = BOOT.
  - imem_req = 0, fetch_valid = 0, fetch_pc = RESET_VECTOR, halted = 0.
  - Pending-redirect register cleared.
- States:
  - BOOT: one idle cycle after reset deasserts, then go to FETCH.
  - FETCH:
    - If stall = 1: imem_req = 0, pc held.
    - Otherwise: imem_req = 1, imem_addr = pc; go to WAIT.
  - WAIT: imem_req held at 1, address held. On imem_ack the fetch completes; the rules below decide what happens.
  - HALTED: imem_req = 0, halted = 1; only reset exits.
- imem_req:
  - Registered; asserted the cycle after FETCH is entered with stall = 0.
  - Held until imem_ack.
  - The address must not change while imem_req is high.
- Next-PC selection, evaluated on the ack cycle:
  - Priority: jump (jump_target) > branch_taken (branch_target) > pending redirect > pc + PC_STEP.
- Redirect during WAIT:
  - jump or branch_taken asserted on a non-ack cycle is latched as pending; jump overwrites branch.
  - The in-flight fetch is then discarded: fetch_valid stays 0 on its ack, and pc loads the pending target.
- Redirect on the ack cycle:
  - The returned instruction is discarded (fetch_valid = 0).
  - pc loads the redirect target.
- Normal completion:
  - fetch_valid = 1 for exactly one cycle, coincident with the cycle after ack.
  - fetch_pc = address of the acknowledged fetch.
  - pc advances; state returns to FETCH.
- Stall:
  - Only prevents issuing a new request; it does not abort a request already in WAIT.
  - A redirect asserted during stall in FETCH loads pc immediately, next cycle.
- Halt:
  - Sampled in FETCH or on the ack cycle.
  - In FETCH: go to HALTED without a request.
  - In WAIT: the current fetch completes normally (fetch_valid pulses if not redirected), then HALTED.
- Arithmetic:
  - Unsigned, modulo 2^ADDR_WIDTH: 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000.
  - Targets have bits [1:0] forced to 0 before loading.
- Throughput: at most one fetch per 2 cycles (FETCH then WAIT) with single-cycle ack.
- Reset mid-WAIT: the request drops immediately; any late imem_ack is ignored because state is BOOT.

Decomposition:
- Shared package holds:
  - State encoding constants: BOOT = 2'd0, FETCH = 2'd1, WAIT = 2'd2, HALTED = 2'd3.
  - PC_STEP and RESET_VECTOR defaults.
  - Address-alignment mask.
- Sub-module: the existing PC adder (pcOld to pcNew, +4), instantiated for pc_plus4. The FSM and next-PC mux stay in this block.

Test Plan:
- Reset then free-run with imem_ack the cycle after every request -> imem_addr sequence 0x0, 0x4, 0x8, 0xC; fetch_valid pulses every 2 cycles; fetch_pc matches each address.
- Jump asserted during WAIT at pc=0x8 with jump_target=0x100, ack delayed 3 cycles -> no fetch_valid for 0x8; next imem_addr = 0x100.
- Same cycle: branch_taken (target 0x40) and jump (target 0x80) on the ack cycle -> pc = 0x80; branch ignored.
- stall held 5 cycles in FETCH at pc=0x10 -> imem_req = 0 throughout, pc = 0x10; request for 0x10 issued the cycle after stall falls.
- RESET_VECTOR = 0xFFFF_FFF8, free-run -> addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; jump_target 0x103 loads as 0x100.
- Halt during WAIT at pc=0x20 -> fetch_valid for 0x20, then halted = 1 and imem_req = 0 indefinitely; async reset mid-WAIT returns pc to RESET_VECTOR in the same cycle.
